sim_param_scheduler: RTL and testbench

// - Host-side parameter bank and commit scheduler for the spindle / neuron_pool / muscle datapath.
// - Replaces the per-parameter registers clocked by okTriggerIn bits with one synchronous block.
// - Host writes {hi,lo} words into shadow slots via trigger bits.
// - Shadow values are committed to live outputs only on a simulation-step boundary (sim_clk rising edge).

---
 rtl/sim_param_pkg.sv | 46 ++++
 rtl/sim_param_scheduler_param_slot.sv | 50 +++++
 rtl/sim_param_scheduler.sv | 104 ++++++++++
 tb/tb_sim_param_scheduler.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sim_param_pkg.sv
// Shared constants, slot map, reset table and FSM encoding for sim_param_scheduler.
package sim_param_pkg;

    localparam int unsigned NSLOT  = 16;
    localparam int unsigned DW     = 32;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned OVW_W  = 8;
    localparam int unsigned SEL_W  = 4;

    // Slot map shared with the spindle / neuron_pool / muscle datapath
    localparam int unsigned SLOT_PPS_IA   = 1;
    localparam int unsigned SLOT_PPS_II   = 2;
    localparam int unsigned SLOT_GAIN     = 3;
    localparam int unsigned SLOT_GDYN     = 4;
    localparam int unsigned SLOT_GSTA     = 5;
    localparam int unsigned SLOT_GAIN_MN  = 6;
    localparam int unsigned SLOT_DLY      = 7;
    localparam int unsigned SLOT_BD_CHAIN = 13;
    localparam int unsigned SLOT_BD2      = 14;
    localparam int unsigned SLOT_BD1      = 15;

    // Power-on / global-reset value of every slot, index 0 first
    localparam logic [DW-1:0] SLOT_RESET [0:NSLOT-1] = '{
        32'h0000_0000, 32'h3F66_6666, 32'h3F66_6666, 32'h0000_0000,
        32'h42A0_0000, 32'h42A0_0000, 32'h0000_0001, 32'h0000_01F4,
        32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
        32'h0000_0000, 32'h3C58_44D0, 32'h3D14_4674, 32'h3E71_4120
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_COMMIT = 2'd2
    } sched_state_e;

    // Word a trigger loads into a slot; the delay slot is an integer with no high half
    function automatic logic [DW-1:0] slot_word(input int unsigned idx,
                                                input logic [WORD_W-1:0] hi,
                                                input logic [WORD_W-1:0] lo);
        if (idx == SLOT_DLY) begin
            return {WORD_W'(0), lo};
        end
        return {hi, lo};
    endfunction

endpackage

// File: rtl/sim_param_scheduler_param_slot.sv
// One parameter slot: host-written shadow, committed live value and pending flag.
module param_slot
    import sim_param_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DW-1:0] rst_val_i,
    input  logic          load_i,
    input  logic [DW-1:0] data_i,
    input  logic          commit_i,
    output logic [DW-1:0] live_o,
    output logic          pending_o
);

    logic [DW-1:0] shadow_q, shadow_d;
    logic [DW-1:0] live_q, live_d;
    logic          pending_q, pending_d;

    // A commit moves the old shadow to live even if a new word lands in the same cycle
    always_comb begin
        shadow_d  = shadow_q;
        live_d    = live_q;
        pending_d = pending_q;
        if (commit_i && pending_q) begin
            live_d    = shadow_q;
            pending_d = 1'b0;
        end
        if (load_i) begin
            shadow_d  = data_i;
            pending_d = 1'b1;
        end
    end

    // Slot registers with synchronous global reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shadow_q  <= rst_val_i;
            live_q    <= rst_val_i;
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            live_q    <= live_d;
            pending_q <= pending_d;
        end
    end

    assign live_o    = live_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/sim_param_scheduler.sv
// Host parameter bank that commits shadow values only on simulation-step boundaries.
// Optional readback mux enabled by defining SIM_PARAM_READBACK_EN.
module sim_param_scheduler
    import sim_param_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NSLOT-1:0]    trig,
    input  logic [WORD_W-1:0]   wr_lo,
    input  logic [WORD_W-1:0]   wr_hi,
    input  logic                sim_tick,
    input  logic                sim_reset,
    output logic [NSLOT*DW-1:0] param_flat,
    output logic [NSLOT-1:0]    pending,
    output logic                commit_pulse,
    output logic [OVW_W-1:0]    ovw_cnt,
    input  logic [SEL_W-1:0]    rd_sel,
    output logic [DW-1:0]       rd_data
);

    sched_state_e     state_q, state_d;
    logic             tick_q;
    logic             rise_c;
    logic             commit_c;
    logic             commit_pulse_q;
    logic [OVW_W-1:0] ovw_cnt_q, ovw_cnt_d;
    logic [NSLOT-1:0] pending_w;
    logic [DW-1:0]    live_w [NSLOT];

    assign rise_c   = sim_tick & ~tick_q;
    assign commit_c = (state_q == ST_COMMIT);

    // Slot array; all slots share the commit strobe
    for (genvar i = 0; i < NSLOT; i++) begin : g_slot
        param_slot u_slot (
            .clk       (clk),
            .reset_n   (reset_n),
            .rst_val_i (SLOT_RESET[i]),
            .load_i    (trig[i]),
            .data_i    (slot_word(i, wr_hi, wr_lo)),
            .commit_i  (commit_c),
            .live_o    (live_w[i]),
            .pending_o (pending_w[i])
        );
        assign param_flat[i*DW +: DW] = live_w[i];
    end

    // Next-state and overwrite-counter logic
    always_comb begin
        state_d   = state_q;
        ovw_cnt_d = ovw_cnt_q;
        if (|(trig & pending_w) && (ovw_cnt_q != {OVW_W{1'b1}})) begin
            ovw_cnt_d = ovw_cnt_q + OVW_W'(1);
        end
        unique case (state_q)
            ST_IDLE:   if (|trig) state_d = ST_ARMED;
            ST_ARMED:  if (rise_c || sim_reset) state_d = ST_COMMIT;
            ST_COMMIT: state_d = (|trig) ? ST_ARMED : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State, tick sampler, commit pulse and overwrite counter registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            tick_q         <= 1'b0;
            commit_pulse_q <= 1'b0;
            ovw_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            tick_q         <= sim_tick;
            commit_pulse_q <= (state_d == ST_COMMIT);
            ovw_cnt_q      <= ovw_cnt_d;
        end
    end

    assign pending      = pending_w;
    assign commit_pulse = commit_pulse_q;
    assign ovw_cnt      = ovw_cnt_q;

`ifdef SIM_PARAM_READBACK_EN
    logic [DW-1:0] rd_data_q;

    // Registered readback of the live value of the selected slot
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else if (32'(rd_sel) < NSLOT) begin
            rd_data_q <= live_w[rd_sel];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign rd_data = rd_data_q;
`else
    logic rd_sel_unused;

    assign rd_sel_unused = ^rd_sel;
    assign rd_data       = '0;
`endif

endmodule

// File: tb/tb_sim_param_scheduler.sv
// Randomized and directed bench for sim_param_scheduler against a behavioural model.
module tb_sim_param_scheduler;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [15:0]    trig = '0;
    logic [15:0]    wr_lo = '0;
    logic [15:0]    wr_hi = '0;
    logic           sim_tick = 1'b0;
    logic           sim_reset = 1'b0;
    logic [511:0]   param_flat;
    logic [15:0]    pending;
    logic           commit_pulse;
    logic [7:0]     ovw_cnt;
    logic [3:0]     rd_sel = '0;
    logic [31:0]    rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] live_m   [16];
    logic [31:0] shadow_m [16];
    logic [15:0] pend_m;
    int          st_m;      // 0 idle, 1 armed, 2 commit
    logic        tick_m;
    int          ovw_m;
    logic        cp_m;
    logic [31:0] rd_m;

    sim_param_scheduler dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .trig         (trig),
        .wr_lo        (wr_lo),
        .wr_hi        (wr_hi),
        .sim_tick     (sim_tick),
        .sim_reset    (sim_reset),
        .param_flat   (param_flat),
        .pending      (pending),
        .commit_pulse (commit_pulse),
        .ovw_cnt      (ovw_cnt),
        .rd_sel       (rd_sel),
        .rd_data      (rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] reset_val(input int idx);
        case (idx)
            1, 2:    return 32'h3F66_6666;
            4, 5:    return 32'h42A0_0000;
            6:       return 32'h0000_0001;
            7:       return 32'h0000_01F4;
            13:      return 32'h3C58_44D0;
            14:      return 32'h3D14_4674;
            15:      return 32'h3E71_4120;
            default: return 32'h0000_0000;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] live_of(input int idx);
        return param_flat[idx*32 +: 32];
    endfunction

    // Apply one clock edge worth of behaviour to the model
    task automatic model_step(input logic [15:0] t, input logic [15:0] lo, input logic [15:0] hi,
                              input logic tk, input logic sr, input logic [3:0] rs, input logic rn);
        logic rise;
        int   nxt;
        if (!rn) begin
            for (int i = 0; i < 16; i++) begin
                live_m[i]   = reset_val(i);
                shadow_m[i] = reset_val(i);
            end
            pend_m = '0; st_m = 0; tick_m = 1'b0; ovw_m = 0; cp_m = 1'b0; rd_m = '0;
            return;
        end
        rise = tk & ~tick_m;
`ifdef SIM_PARAM_READBACK_EN
        rd_m = live_m[rs];
`else
        rd_m = '0;
`endif
        if (st_m == 2) begin
            for (int i = 0; i < 16; i++) if (pend_m[i]) live_m[i] = shadow_m[i];
        end
        if ((t & pend_m) != 0 && ovw_m < 255) ovw_m++;
        for (int i = 0; i < 16; i++) begin
            if (t[i]) shadow_m[i] = (i == 7) ? {16'h0000, lo} : {hi, lo};
        end
        pend_m = t | ((st_m == 2) ? 16'h0000 : pend_m);
        case (st_m)
            1:       nxt = (rise || sr) ? 2 : 1;
            default: nxt = (t != 0) ? 1 : 0;
        endcase
        cp_m   = (nxt == 2);
        st_m   = nxt;
        tick_m = tk;
    endtask

    task automatic compare_all();
        for (int i = 0; i < 16; i++) check_eq($sformatf("live%0d", i), 64'(live_of(i)), 64'(live_m[i]));
        check_eq("pending", 64'(pending), 64'(pend_m));
        check_eq("commit_pulse", 64'(commit_pulse), 64'(cp_m));
        check_eq("ovw_cnt", 64'(ovw_cnt), 64'(ovw_m));
        check_eq("rd_data", 64'(rd_data), 64'(rd_m));
    endtask

    // Drive one cycle at the falling edge, advance model, then compare at the next falling edge
    task automatic cyc(input logic [15:0] t, input logic [15:0] lo, input logic [15:0] hi,
                       input logic tk, input logic sr, input logic [3:0] rs, input logic rn);
        trig = t; wr_lo = lo; wr_hi = hi; sim_tick = tk; sim_reset = sr; rd_sel = rs; reset_n = rn;
        model_step(t, lo, hi, tk, sr, rs, rn);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input logic tk, input logic sr);
        cyc(16'h0, 16'h0, 16'h0, tk, sr, 4'($urandom_range(15)), 1'b1);
    endtask

    initial begin
        logic [15:0] t;
        logic        tk;
        @(negedge clk);

        // Reset and reset values
        cyc(16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc(16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 4'd0, 1'b0);
        check_eq("rst_slot4", 64'(live_of(4)), 64'h42A0_0000);
        check_eq("rst_slot15", 64'(live_of(15)), 64'h3E71_4120);
        check_eq("rst_pending", 64'(pending), 64'h0);
        check_eq("rst_pulse", 64'(commit_pulse), 64'h0);
        for (int i = 0; i < 16; i++) idle(1'b0, 1'b0);

        // Load slot 4, commit on a tick with two-edge latency
        cyc(16'h0010, 16'h0000, 16'h4220, 1'b0, 1'b0, 4'd4, 1'b1);
        check_eq("ld4_pending", 64'(pending[4]), 64'h1);
        check_eq("ld4_live_hold", 64'(live_of(4)), 64'h42A0_0000);
        idle(1'b0, 1'b0);
        idle(1'b1, 1'b0);
        check_eq("tick_edge1_live", 64'(live_of(4)), 64'h42A0_0000);
        check_eq("tick_edge1_pulse", 64'(commit_pulse), 64'h1);
        idle(1'b1, 1'b0);
        check_eq("tick_edge2_live", 64'(live_of(4)), 64'h4220_0000);
        check_eq("tick_edge2_pend", 64'(pending), 64'h0);
        check_eq("tick_edge2_pulse", 64'(commit_pulse), 64'h0);

        // Overwrite before tick
        idle(1'b0, 1'b0);
        cyc(16'h0002, 16'h0000, 16'h3F00, 1'b0, 1'b0, 4'd1, 1'b1);
        cyc(16'h0002, 16'h0000, 16'h3F40, 1'b0, 1'b0, 4'd1, 1'b1);
        check_eq("ovw_one", 64'(ovw_cnt), 64'd1);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        check_eq("ovw_live1", 64'(live_of(1)), 64'h3F40_0000);

        // Collision: load during the commit cycle
        idle(1'b0, 1'b0);
        cyc(16'h0020, 16'h0000, 16'h3F80, 1'b0, 1'b0, 4'd5, 1'b1);
        idle(1'b1, 1'b0);
        cyc(16'h0020, 16'h0000, 16'h4000, 1'b1, 1'b0, 4'd5, 1'b1);
        check_eq("coll_live_old", 64'(live_of(5)), 64'h3F80_0000);
        check_eq("coll_pend5", 64'(pending[5]), 64'h1);
        idle(1'b0, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        check_eq("coll_live_new", 64'(live_of(5)), 64'h4000_0000);

        // Halted simulation commits without a tick; delay slot ignores wr_hi
        idle(1'b0, 1'b1);
        cyc(16'h0080, 16'h0100, 16'hFFFF, 1'b0, 1'b1, 4'd7, 1'b1);
        idle(1'b0, 1'b1);
        check_eq("halt_not_yet", 64'(live_of(7)), 64'h0000_01F4);
        idle(1'b0, 1'b1);
        check_eq("halt_live7", 64'(live_of(7)), 64'h0000_0100);
        idle(1'b0, 1'b0);

        // Global reset while armed discards pending loads
        cyc(16'h0008, 16'h1234, 16'h5678, 1'b0, 1'b0, 4'd3, 1'b1);
        cyc(16'h0000, 16'h0, 16'h0, 1'b0, 1'b0, 4'd3, 1'b0);
        check_eq("rst_arm_pend", 64'(pending), 64'h0);
        check_eq("rst_arm_live3", 64'(live_of(3)), 64'h0);
        check_eq("rst_arm_live7", 64'(live_of(7)), 64'h0000_01F4);
        idle(1'b0, 1'b0);
        idle(1'b1, 1'b0);
        check_eq("rst_arm_nopulse1", 64'(commit_pulse), 64'h0);
        idle(1'b1, 1'b0);
        check_eq("rst_arm_nopulse2", 64'(commit_pulse), 64'h0);

        // Overwrite counter saturation
        idle(1'b0, 1'b0);
        for (int i = 0; i < 260; i++) cyc(16'h0004, 16'(i), 16'hABCD, 1'b0, 1'b0, 4'd2, 1'b1);
        check_eq("ovw_sat", 64'(ovw_cnt), 64'd255);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        cyc(16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 4'd0, 1'b0);

        // Randomized traffic
        tk = 1'b0;
        for (int n = 0; n < 500; n++) begin
            t = '0;
            if ($urandom_range(3) == 0) t = 16'(1) << $urandom_range(15);
            if ($urandom_range(2) == 0) tk = ~tk;
            cyc(t, 16'($urandom), 16'($urandom), tk, ($urandom_range(15) == 0),
                4'($urandom_range(15)), ($urandom_range(63) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
